// File: rtl/rtc_bcd_timekeeper.sv
// rtc_bcd_timekeeper: BCD hh:mm:ss time-of-day counter advanced by a 1 Hz tick,
// with start/stop, clear, validated parallel load and optional 12-hour AM/PM counting.
module rtc_bcd_timekeeper #(
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       ld_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       running,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       load_err
);
    typedef enum logic {HOLD, RUN} state_t;

    localparam logic [7:0] HH_RST = MODE_24H ? 8'h00 : 8'h12;

    state_t     state_q, state_d;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic       pm_q, pm_d;
    logic       min_q, min_d, hour_q, hour_d, day_q, day_d, err_q, err_d;
    logic       ld_bad, s_wrap, m_wrap;

    // Two-digit BCD increment without wrap; callers handle the wrap points.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign ld_bad = (ld_ss[3:0] > 4'd9) || (ld_mm[3:0] > 4'd9) || (ld_hh[3:0] > 4'd9)
                 || (ld_ss[7:4] > 4'd5) || (ld_mm[7:4] > 4'd5)
                 || (MODE_24H ? (ld_hh > 8'h23) : (ld_hh == 8'h00 || ld_hh > 8'h12));
    assign s_wrap = (ss_q == 8'h59);
    assign m_wrap = (mm_q == 8'h59);

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        pm_d    = pm_q;
        min_d   = 1'b0;
        hour_d  = 1'b0;
        day_d   = 1'b0;
        err_d   = 1'b0;
        if (stop)
            state_d = HOLD;
        else if (start)
            state_d = RUN;
        if (clear) begin
            state_d = HOLD;
            hh_d    = HH_RST;
            mm_d    = 8'h00;
            ss_d    = 8'h00;
            pm_d    = 1'b0;
        end else if (load) begin
            err_d = ld_bad;
            if (!ld_bad) begin
                hh_d = ld_hh;
                mm_d = ld_mm;
                ss_d = ld_ss;
                pm_d = MODE_24H ? 1'b0 : ld_pm;
            end
        end else if (tick_1hz && state_q == RUN) begin
            ss_d  = s_wrap ? 8'h00 : bcd_inc(ss_q);
            min_d = s_wrap;
            if (s_wrap) begin
                mm_d   = m_wrap ? 8'h00 : bcd_inc(mm_q);
                hour_d = m_wrap;
            end
            if (s_wrap && m_wrap) begin
                if (MODE_24H) begin
                    hh_d  = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
                    day_d = (hh_q == 8'h23);
                end else begin
                    // 11->12 flips AM/PM; only the PM->AM flip is midnight.
                    hh_d  = (hh_q == 8'h12) ? 8'h01 : bcd_inc(hh_q);
                    pm_d  = (hh_q == 8'h11) ? ~pm_q : pm_q;
                    day_d = (hh_q == 8'h11) && pm_q;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= HOLD;
            hh_q    <= HH_RST;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            pm_q    <= 1'b0;
            min_q   <= 1'b0;
            hour_q  <= 1'b0;
            day_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            pm_q    <= pm_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            err_q   <= err_d;
        end
    end

    assign hh         = hh_q;
    assign mm         = mm_q;
    assign ss         = ss_q;
    assign pm         = pm_q;
    assign running    = (state_q == RUN);
    assign min_pulse  = min_q;
    assign hour_pulse = hour_q;
    assign day_pulse  = day_q;
    assign load_err   = err_q;
endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// tb_rtc_bcd_timekeeper: 24h and 12h instances against a seconds-of-day reference
// model, plus a directed vector table and hand-written rollover sequences.
module tb_rtc_bcd_timekeeper;
    logic       clk = 1'b0;
    logic       rst, start, stop, clear, load, tick, ld_pm;
    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
    logic       pm24, run24, min24, hr24, day24, err24;
    logic       pm12, run12, min12, hr12, day12, err12;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference state per mode (0 = 24h, 1 = 12h): seconds since midnight.
    int         secs [2];
    bit         run [2], mp [2], hp [2], dp [2], er [2];

    always #5 clk = ~clk;

    rtc_bcd_timekeeper #(.MODE_24H(1'b1)) d24 (
        .clk_in(clk), .reset(rst), .tick_1hz(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .ld_pm(ld_pm), .hh(hh24), .mm(mm24), .ss(ss24), .pm(pm24), .running(run24),
        .min_pulse(min24), .hour_pulse(hr24), .day_pulse(day24), .load_err(err24));

    rtc_bcd_timekeeper #(.MODE_24H(1'b0)) d12 (
        .clk_in(clk), .reset(rst), .tick_1hz(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .ld_pm(ld_pm), .hh(hh12), .mm(mm12), .ss(ss12), .pm(pm12), .running(run12),
        .min_pulse(min12), .hour_pulse(hr12), .day_pulse(day12), .load_err(err12));

    typedef struct {
        logic r, st, sp, cl, ld, tk;
        logic [7:0] lh, lm, ls;
        logic lp;
        logic [7:0] eh, em, es;
        logic erun, emin, ehr, eday, eerr;
    } vec_t;
    vec_t tv [25];

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + n % 10);
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return (v[7:4] > 9 || v[3:0] > 9) ? -1 : int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        int h, mi, s;
        bit was_run, ok;
        if (rst) begin
            secs[m] = 0; run[m] = 0; mp[m] = 0; hp[m] = 0; dp[m] = 0; er[m] = 0;
            return;
        end
        was_run = run[m];
        mp[m] = 0; hp[m] = 0; dp[m] = 0; er[m] = 0;
        if (stop) run[m] = 0;
        else if (start) run[m] = 1;
        if (clear) begin
            secs[m] = 0;
            run[m]  = 0;
        end else if (load) begin
            h  = bcd_val(ld_hh);
            mi = bcd_val(ld_mm);
            s  = bcd_val(ld_ss);
            ok = h >= 0 && mi >= 0 && s >= 0 && mi < 60 && s < 60
                 && (m == 0 ? h < 24 : (h >= 1 && h <= 12));
            if (!ok) er[m] = 1;
            else secs[m] = ((m == 0) ? h : (h % 12) + (ld_pm ? 12 : 0)) * 3600 + mi * 60 + s;
        end else if (tick && was_run) begin
            secs[m] = (secs[m] + 1) % 86400;
            mp[m] = (secs[m] % 60 == 0);
            hp[m] = (secs[m] % 3600 == 0);
            dp[m] = (secs[m] == 0);
        end
    endtask

    task automatic cmp_dut(input int m);
        int h24;
        h24 = secs[m] / 3600;
        chk($sformatf("m%0d_hh", m), m == 0 ? hh24 : hh12,
            to_bcd(m == 0 ? h24 : (h24 % 12 == 0 ? 12 : h24 % 12)));
        chk($sformatf("m%0d_mm", m), m == 0 ? mm24 : mm12, to_bcd((secs[m] / 60) % 60));
        chk($sformatf("m%0d_ss", m), m == 0 ? ss24 : ss12, to_bcd(secs[m] % 60));
        chk($sformatf("m%0d_pm", m), m == 0 ? pm24 : pm12, (m == 1 && h24 >= 12));
        chk($sformatf("m%0d_running", m), m == 0 ? run24 : run12, run[m]);
        chk($sformatf("m%0d_min_pulse", m), m == 0 ? min24 : min12, mp[m]);
        chk($sformatf("m%0d_hour_pulse", m), m == 0 ? hr24 : hr12, hp[m]);
        chk($sformatf("m%0d_day_pulse", m), m == 0 ? day24 : day12, dp[m]);
        chk($sformatf("m%0d_load_err", m), m == 0 ? err24 : err12, er[m]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        {rst, start, stop, clear, load, tick} = '0;
        cmp_dut(0);
        cmp_dut(1);
    endtask

    task automatic set_ld(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s, input logic p);
        ld_hh = h; ld_mm = mi; ld_ss = s; ld_pm = p;
    endtask

    initial begin
        int cnt;
        {rst, start, stop, clear, load, tick, ld_pm} = '0;
        {ld_hh, ld_mm, ld_ss} = '0;
        //        r st sp cl ld tk  lh     lm     ls    lp  eh     em     es   run mn hr dy er
        tv[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 1, 0, 8'h23, 8'h59, 8'h58, 0, 8'h23, 8'h59, 8'h58, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h23, 8'h59, 8'h58, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h23, 8'h59, 8'h58, 1, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0};
        tv[7]  = '{0, 0, 0, 0, 1, 0, 8'h01, 8'h02, 8'h60, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1};
        tv[8]  = '{0, 0, 0, 0, 1, 0, 8'h24, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0};
        tv[10] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0, 0};
        tv[11] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h02, 1, 0, 0, 0, 0};
        tv[12] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h03, 1, 0, 0, 0, 0};
        tv[13] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h04, 1, 0, 0, 0, 0};
        tv[14] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h05, 1, 0, 0, 0, 0};
        tv[15] = '{0, 0, 0, 0, 1, 1, 8'h10, 8'h20, 8'h30, 0, 8'h10, 8'h20, 8'h30, 1, 0, 0, 0, 0};
        tv[16] = '{0, 0, 0, 1, 1, 1, 8'h12, 8'h34, 8'h7A, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        tv[17] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        tv[18] = '{0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        tv[19] = '{0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0};
        tv[20] = '{0, 0, 0, 0, 1, 0, 8'h05, 8'h06, 8'h07, 0, 8'h05, 8'h06, 8'h07, 1, 0, 0, 0, 0};
        tv[21] = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        tv[22] = '{0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0};
        tv[23] = '{0, 0, 0, 0, 1, 0, 8'h23, 8'h59, 8'h59, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0, 0, 0};
        tv[24] = '{1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            {rst, start, stop, clear, load, tick} = {tv[i].r, tv[i].st, tv[i].sp, tv[i].cl, tv[i].ld, tv[i].tk};
            set_ld(tv[i].lh, tv[i].lm, tv[i].ls, tv[i].lp);
            step();
            chk($sformatf("tv%0d_hh", i), hh24, tv[i].eh);
            chk($sformatf("tv%0d_mm", i), mm24, tv[i].em);
            chk($sformatf("tv%0d_ss", i), ss24, tv[i].es);
            chk($sformatf("tv%0d_flags", i), {run24, min24, hr24, day24, err24},
                {tv[i].erun, tv[i].emin, tv[i].ehr, tv[i].eday, tv[i].eerr});
        end
        // 60 ticks from 00:00:00: exactly one min_pulse, coinciding with ss=00.
        start = 1;
        step();
        cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick = 1;
            step();
            chk($sformatf("t1_ss_%0d", i), ss24, to_bcd(i % 60));
            if (min24) begin
                cnt++;
                chk("t1_min_with_ss00", ss24, 8'h00);
            end
            step();
        end
        chk("t1_min_count", cnt, 1);
        chk("t1_mm", mm24, 8'h01);
        // 12h: AM->PM at noon without day_pulse, PM->AM at midnight with it.
        load = 1; set_ld(8'h11, 8'h59, 8'h59, 0);
        step();
        tick = 1;
        step();
        chk("t3_noon_hh", hh12, 8'h12);
        chk("t3_noon_pm", pm12, 1);
        chk("t3_noon_day", day12, 0);
        load = 1; set_ld(8'h11, 8'h59, 8'h59, 1);
        step();
        tick = 1;
        step();
        chk("t3_mid_hh", {hh12, mm12, ss12}, 24'h120000);
        chk("t3_mid_pm", pm12, 0);
        chk("t3_mid_day", day12, 1);
        // hh=00 is illegal only in 12h mode.
        load = 1; set_ld(8'h00, 8'h00, 8'h00, 0);
        step();
        chk("t4_12h_err", err12, 1);
        chk("t4_12h_hh", hh12, 8'h12);
        chk("t4_24h_noerr", err24, 0);
        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            clear = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 9) == 0);
            tick  = ($urandom_range(0, 1) == 0);
            ld_hh = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 23))) : 8'($urandom);
            ld_mm = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(55, 59))) : 8'($urandom);
            ld_ss = ($urandom_range(0, 1) != 0) ? to_bcd(int'($urandom_range(50, 59))) : 8'($urandom);
            ld_pm = 1'($urandom_range(0, 1));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
